// File: rtl/xmpl_fft_pkg.sv
// xmpl_fft_pkg
//   Shared types and helpers for the xmpl_fft output unloader.
//   - bank_state_e : life cycle of one ping-pong buffer bank
//   - FFT_LEN_MIN / FFT_LEN_MAX : legal frame lengths (powers of two)
//   - bitrev()     : reverse the low 'width' bits of an index
package xmpl_fft_pkg;

  localparam int FFT_LEN_MIN = 4;
  localparam int FFT_LEN_MAX = 4096;
  localparam int BITREV_W    = 12;  // $clog2(FFT_LEN_MAX)

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Bits at or above 'width' come back as zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] addr,
                                                 input int width);
    logic [BITREV_W-1:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = addr[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/xmpl_fft_bank_ram.sv
// xmpl_fft_bank_ram
//   Simple dual-port RAM holding both ping-pong banks (bank = address MSB).
//   Ports:
//     clk      : clock, rising edge
//     wr_en    : write strobe
//     wr_addr  : write address {bank, bin}
//     wr_data  : write data
//     rd_en    : read strobe; rd_data updates one clock later
//     rd_addr  : read address {bank, bin}
//     rd_data  : registered read data, holds its value while rd_en is low
module xmpl_fft_bank_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/xmpl_fft_unloader.sv
// xmpl_fft_unloader
//   Reorders xmpl_fft results from bit-reversed to natural bin order using a
//   two-bank ping-pong buffer: one frame loads while the previous one drains.
//   Ports:
//     clk_i, reset_n_i          : clock, synchronous active-low reset
//     s_valid_i/s_data_i/s_last_i/s_ready_o : input stream, k-th sample = bin bitrev(k)
//     m_valid_o/m_data_o/m_index_o/m_last_o/m_ready_i : output stream, natural order
//     frame_err_o               : one-clock pulse when a frame had a misplaced s_last_i
module xmpl_fft_unloader
  import xmpl_fft_pkg::*;
#(
  parameter  int FFT_LEN = 64,
  parameter  int DATA_W  = 32,
  localparam int ADDR_W  = $clog2(FFT_LEN)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] m_index_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              frame_err_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_LEN - 1);

  bank_state_e       bank_st     [2];
  bank_state_e       bank_st_nxt [2];
  logic              wr_bank, wr_bank_nxt;
  logic              iss_bank, iss_bank_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_nxt;
  logic [ADDR_W-1:0] iss_cnt, iss_cnt_nxt;
  logic              s_ready_nxt;

  logic              s_hs;
  logic              frame_bad;
  logic              out_pop;
  logic              a_free;
  logic              rd_issue;
  logic [ADDR_W-1:0] wr_bin;

  logic [DATA_W-1:0] ram_rdata;
  logic              rd_v;
  logic [ADDR_W-1:0] rd_idx;
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_idx;

  assign s_hs      = s_valid_i & s_ready_o;
  assign frame_bad = s_hs & (s_last_i != (wr_cnt == LAST_IDX));
  assign out_pop   = m_valid_o & m_ready_i;
  assign wr_bin    = ADDR_W'(bitrev(BITREV_W'(wr_cnt), ADDR_W));

  // The RAM output register is the first skid slot. It is free for a new
  // read when empty, when it moves into the skid register, or when it is
  // handed downstream this clock.
  assign a_free = !rd_v || !skid_v || out_pop;

  // iss_bank moves on as soon as the last read of a frame is issued, so the
  // next full bank starts reading while the previous one is still draining.
  // DRAINING with iss_cnt==0 means every read of that bank is already out.
  assign rd_issue = a_free &&
                    ((bank_st[iss_bank] == FULL) ||
                     (bank_st[iss_bank] == DRAINING && iss_cnt != '0));

  assign m_valid_o = skid_v | rd_v;
  assign m_data_o  = skid_v ? skid_data : (rd_v ? ram_rdata : '0);
  assign m_index_o = skid_v ? skid_idx  : (rd_v ? rd_idx    : '0);
  assign m_last_o  = m_valid_o && (m_index_o == LAST_IDX);

  xmpl_fft_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (s_hs),
    .wr_addr ({wr_bank, wr_bin}),
    .wr_data (s_data_i),
    .rd_en   (rd_issue),
    .rd_addr ({iss_bank, iss_cnt}),
    .rd_data (ram_rdata)
  );

  // Next-state for the bank FSMs and pointers. Write and read sides only ever
  // touch banks in disjoint states, so their updates never collide.
  always_comb begin
    bank_st_nxt  = bank_st;
    wr_bank_nxt  = wr_bank;
    iss_bank_nxt = iss_bank;
    rd_bank_nxt  = rd_bank;
    wr_cnt_nxt   = wr_cnt;
    iss_cnt_nxt  = iss_cnt;

    if (s_hs) begin
      if (frame_bad) begin
        bank_st_nxt[wr_bank] = EMPTY;
        wr_cnt_nxt           = '0;
      end else if (wr_cnt == LAST_IDX) begin
        bank_st_nxt[wr_bank] = FULL;
        wr_cnt_nxt           = '0;
        wr_bank_nxt          = ~wr_bank;
      end else begin
        bank_st_nxt[wr_bank] = FILLING;
        wr_cnt_nxt           = wr_cnt + 1'b1;
      end
    end

    if (rd_issue) begin
      bank_st_nxt[iss_bank] = DRAINING;
      if (iss_cnt == LAST_IDX) begin
        iss_cnt_nxt  = '0;
        iss_bank_nxt = ~iss_bank;
      end else begin
        iss_cnt_nxt = iss_cnt + 1'b1;
      end
    end

    if (out_pop && m_last_o) begin
      bank_st_nxt[rd_bank] = EMPTY;
      rd_bank_nxt          = ~rd_bank;
    end

    s_ready_nxt = (bank_st_nxt[wr_bank_nxt] == EMPTY) ||
                  (bank_st_nxt[wr_bank_nxt] == FILLING);
  end

  // State registers, registered s_ready_o / frame_err_o, and the output skid.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      wr_bank     <= 1'b0;
      iss_bank    <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      iss_cnt     <= '0;
      s_ready_o   <= 1'b0;
      frame_err_o <= 1'b0;
      rd_v        <= 1'b0;
      rd_idx      <= '0;
      skid_v      <= 1'b0;
      skid_data   <= '0;
      skid_idx    <= '0;
    end else begin
      bank_st     <= bank_st_nxt;
      wr_bank     <= wr_bank_nxt;
      iss_bank    <= iss_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      wr_cnt      <= wr_cnt_nxt;
      iss_cnt     <= iss_cnt_nxt;
      s_ready_o   <= s_ready_nxt;
      frame_err_o <= frame_bad;

      if (rd_issue) begin
        rd_v   <= 1'b1;
        rd_idx <= iss_cnt;
      end else if (a_free) begin
        rd_v <= 1'b0;
      end

      // Skid holds the older sample; a stalled RAM output slides into it.
      if (!skid_v) begin
        if (rd_v && !out_pop) begin
          skid_v    <= 1'b1;
          skid_data <= ram_rdata;
          skid_idx  <= rd_idx;
        end
      end else if (out_pop) begin
        skid_v    <= rd_v;
        skid_data <= ram_rdata;
        skid_idx  <= rd_idx;
      end
    end
  end

endmodule

// File: tb/tb_xmpl_fft_unloader.sv
// tb_xmpl_fft_unloader
//   Scoreboard bench for xmpl_fft_unloader with FFT_LEN=8, DATA_W=32.
//   Stimulus pushes expected natural-order bins into a queue; an independent
//   monitor pops and compares on every output handshake.
module tb_xmpl_fft_unloader;

  localparam int FFT_LEN = 8;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;
  logic              m_ready;
  logic              frame_err;

  xmpl_fft_unloader #(
    .FFT_LEN (FFT_LEN),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .s_ready_o   (s_ready),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .m_index_o   (m_index),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready),
    .frame_err_o (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } exp_t;

  exp_t expQ[$];

  int errors = 0;
  int checks = 0;
  int errExp = 0;
  int errSeen = 0;
  int lastHsCyc = 0;
  int firstValidCyc = 0;
  int lastPopCyc = 0;
  bit latArm = 1'b0;
  bit checkGaps = 1'b0;
  bit sawBp = 1'b0;
  bit randDone = 1'b0;

  logic              holdPrev = 1'b0;
  logic [DATA_W-1:0] prevData;
  logic [ADDR_W-1:0] prevIdx;
  logic              prevLast;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic boundFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Bin index of the k-th input sample, built by shifting bits into a fresh integer.
  function automatic int refRev(input int k);
    int r = 0;
    for (int i = 0; i < ADDR_W; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic pushExp(input logic [DATA_W-1:0] d, input int b);
    exp_t e;
    e.data = d;
    e.idx  = ADDR_W'(b);
    e.last = (b == FFT_LEN - 1);
    expQ.push_back(e);
  endtask

  task automatic modelFrame(input logic [DATA_W-1:0] d[FFT_LEN]);
    for (int b = 0; b < FFT_LEN; b++)
      for (int k = 0; k < FFT_LEN; k++)
        if (refRev(k) == b) pushExp(d[k], b);
  endtask

  task automatic sendSample(input logic [DATA_W-1:0] d, input logic last, input int gap);
    int w = 0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) boundFail("s_ready_wait");
    lastHsCyc = cyc;
  endtask

  task automatic idleBus();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // kind 0: clean frame; kind 1: s_last at errPos; kind 2: no s_last at k=7
  task automatic applyStimulus(input int kind, input int errPos, input int maxGap);
    logic [DATA_W-1:0] d[FFT_LEN];
    int n;
    for (int k = 0; k < FFT_LEN; k++) d[k] = $urandom;
    n = (kind == 1) ? errPos + 1 : FFT_LEN;
    if (kind == 0) modelFrame(d);
    else errExp++;
    for (int k = 0; k < n; k++) begin
      sendSample(d[k], (kind == 0 && k == FFT_LEN - 1) || (kind == 1 && k == errPos),
                 (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
  endtask

  task automatic waitDrain();
    int w = 0;
    while (expQ.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (expQ.size() != 0) boundFail("drain_wait");
    repeat (4) @(negedge clk);
  endtask

  // Monitor: compares every output handshake against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        holdPrev = 1'b0;
      end else begin
        if (frame_err) errSeen++;
        if (latArm && m_valid) begin
          firstValidCyc = cyc;
          latArm = 1'b0;
        end
        if (holdPrev) begin
          checkOutput("hold_stable", {27'd0, m_valid, m_last, m_index, m_data},
                      {27'd0, 1'b1, prevLast, prevIdx, prevData});
        end
        if (m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: index=%0d data=%0h, none expected", m_index, m_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_data", 64'(m_data), 64'(e.data));
            checkOutput("out_index", 64'(m_index), 64'(e.idx));
            checkOutput("out_last", 64'(m_last), 64'(e.last));
          end
          if (checkGaps && m_index != 0) checkOutput("intra_frame_gap", 64'(cyc), 64'(lastPopCyc + 1));
          lastPopCyc = cyc;
        end
        holdPrev = m_valid && !m_ready;
        prevData = m_data;
        prevIdx  = m_index;
        prevLast = m_last;
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int exp1[FFT_LEN];
    int w;
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_s_ready", 64'(s_ready), 64'd0);
    checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
    checkOutput("reset_m_last", 64'(m_last), 64'd0);
    checkOutput("reset_m_data", 64'(m_data), 64'd0);
    reset_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_s_ready", 64'(s_ready), 64'd1);

    // 1: ramp frame, expected order straight from the reordering table
    $display("[TB] test 1: single ramp frame");
    exp1 = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int b = 0; b < FFT_LEN; b++) pushExp(DATA_W'(exp1[b]), b);
    latArm = 1'b1;
    for (int k = 0; k < FFT_LEN; k++) sendSample(DATA_W'(k), k == FFT_LEN - 1, 0);
    idleBus();
    waitDrain();
    checkOutput("first_out_latency", 64'(firstValidCyc - lastHsCyc), 64'd2);

    // 2: four back-to-back random frames
    $display("[TB] test 2: back-to-back frames");
    checkGaps = 1'b1;
    for (int f = 0; f < 4; f++) applyStimulus(0, 0, 0);
    idleBus();
    waitDrain();
    checkGaps = 1'b0;

    // 3: downstream stall for 20 clocks while streaming
    $display("[TB] test 3: downstream stall");
    sawBp = 1'b0;
    fork
      begin
        for (int f = 0; f < 4; f++) applyStimulus(0, 0, 0);
      end
      begin
        m_ready = 1'b0;
        repeat (20) begin
          @(negedge clk);
          #2;
          if (!s_ready) sawBp = 1'b1;
        end
        @(negedge clk);
        m_ready = 1'b1;
      end
    join
    idleBus();
    checkOutput("backpressure_seen", 64'(sawBp), 64'd1);
    waitDrain();

    // 4: early s_last, then a clean frame
    $display("[TB] test 4: early last");
    applyStimulus(1, 5, 0);
    idleBus();
    applyStimulus(0, 0, 0);
    idleBus();
    waitDrain();
    checkOutput("err_pulse_early_last", 64'(errSeen), 64'(errExp));

    // 5: missing s_last at k=7
    $display("[TB] test 5: missing last");
    applyStimulus(2, 0, 0);
    idleBus();
    repeat (2) @(negedge clk);
    checkOutput("s_ready_after_err", 64'(s_ready), 64'd1);
    checkOutput("err_pulse_missing_last", 64'(errSeen), 64'(errExp));

    // 6: reset while bin 3 is presented
    $display("[TB] test 6: reset mid-drain");
    applyStimulus(0, 0, 0);
    idleBus();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(m_valid && m_index == 3) && w < 100);
    if (!(m_valid && m_index == 3)) boundFail("bin3_wait");
    m_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    expQ.delete();
    #1;
    checkOutput("reset_mid_drain_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_mid_drain_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    checkOutput("reset_mid_drain_s_ready_back", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    applyStimulus(0, 0, 0);
    idleBus();
    waitDrain();

    // 7: random frames, random gaps, random downstream readiness
    $display("[TB] test 7: random traffic");
    randDone = 1'b0;
    fork
      begin
        for (int f = 0; f < 10; f++) begin
          if ($urandom_range(0, 3) == 0)
            applyStimulus(int'($urandom_range(1, 2)), int'($urandom_range(0, 6)), 2);
          else
            applyStimulus(0, 0, 2);
        end
        idleBus();
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(negedge clk);
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    waitDrain();

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("err_pulse_total", 64'(errSeen), 64'(errExp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
